// File: rtl/addsub_pkg.sv
// Shared types and helpers for the 32-bit adder/subtractor result path.
// Holds the queued result record and the signed-overflow rule.
package addsub_pkg;

  localparam int ADDSUB_W = 32;

  typedef struct packed {
    logic [ADDSUB_W-1:0] sum;
    logic                ovf;
    logic                mode;
  } addsub_result_t;

  // Signed overflow from operand/result sign bits; mode 1 means a - b.
  function automatic logic addsub_ovf(input logic [ADDSUB_W-1:0] a,
                                      input logic [ADDSUB_W-1:0] b,
                                      input logic                mode,
                                      input logic [ADDSUB_W-1:0] sum);
    logic sa, sb, ss;
    sa = a[ADDSUB_W-1];
    sb = b[ADDSUB_W-1];
    ss = sum[ADDSUB_W-1];
    if (mode)
      return (sa != sb) && (ss != sa);
    else
      return (sa == sb) && (ss != sa);
  endfunction

endpackage

// File: rtl/addsub_sync_fifo.sv
// Show-ahead synchronous FIFO; entry visible one edge after its push, no bypass.
// Push ignored while full, pop ignored while empty; ready depends on level only.
module addsub_sync_fifo
  import addsub_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = addsub_result_t
) (
  input  logic                     clk,
  input  logic                     rstN,
  input  logic                     push,
  input  T                         wdata,
  input  logic                     pop,
  output T                         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  T               mem [DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic           wr_en;
  logic           rd_en;

  assign full  = (level == LW'(DEPTH));
  assign empty = (level == '0);
  assign wr_en = push && !full;
  assign rd_en = pop && !empty;
  assign rdata = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rstN) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PW'(1);
      if (rd_en) rd_ptr <= rd_ptr + PW'(1);
      case ({wr_en, rd_en})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // Storage is intentionally left out of reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/addsub_result_buffer.sv
// Buffers adder results with an overflow flag and keeps saturating result/overflow counts.
// One-edge latency to out_*; in_ready = !full, independent of out_ready.
module addsub_result_buffer
  import addsub_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rstN,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [ADDSUB_W-1:0]    a,
  input  logic [ADDSUB_W-1:0]    b,
  input  logic                   mode,
  input  logic [ADDSUB_W-1:0]    sum,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ADDSUB_W-1:0]    out_sum,
  output logic                   out_ovf,
  output logic                   out_mode,
  output logic [$clog2(DEPTH):0] level,
  output logic [CNT_W-1:0]       result_cnt,
  output logic [CNT_W-1:0]       ovf_cnt
);

  addsub_result_t wr_dat;
  addsub_result_t rd_dat;
  logic           push;
  logic           pop;
  logic           full;
  logic           empty;

  assign wr_dat.sum  = sum;
  assign wr_dat.ovf  = addsub_ovf(a, b, mode, sum);
  assign wr_dat.mode = mode;

  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign out_sum  = rd_dat.sum;
  assign out_ovf  = rd_dat.ovf;
  assign out_mode = rd_dat.mode;

  addsub_sync_fifo #(
    .DEPTH (DEPTH),
    .T     (addsub_result_t)
  ) u_fifo (
    .clk   (clk),
    .rstN  (rstN),
    .push  (push),
    .wdata (wr_dat),
    .pop   (pop),
    .rdata (rd_dat),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  // Counters only see accepted pushes; a dropped in_valid leaves them alone.
  always_ff @(posedge clk) begin
    if (!rstN) begin
      result_cnt <= '0;
      ovf_cnt    <= '0;
    end else if (push) begin
      if (result_cnt != '1) result_cnt <= result_cnt + CNT_W'(1);
      if (wr_dat.ovf && (ovf_cnt != '1)) ovf_cnt <= ovf_cnt + CNT_W'(1);
    end
  end

endmodule
